sos_coeff_loader: RTL and testbench

- Upstream stage of the cascade SOS IIR chain.
- Accepts a stream of coefficient words over a valid/ready handshake and assembles them into a shadow bank.
- Atomically commits the shadow bank to the active bank on a sample strobe, so coefficients never change mid-sample.
- The active bank drives the coefficient inputs (TYDE_SOS_COEFF_DATA_COF_WD) of every second-order section in the cascade.

---
 rtl/ae_iir_pkg.sv | 27 ++
 rtl/sos_coeff_bank.sv | 50 +++++
 rtl/sos_coeff_loader.sv | 111 +++++++++++
 tb/tb_sos_coeff_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ae_iir_pkg.sv
// Shared types and constants for the cascade SOS IIR chain: coefficient bundle,
// loader FSM states and the unity-passthrough reset value.
package ae_iir_pkg;

  localparam int unsigned COF_WD                = 24;
  localparam int unsigned SHIFT_NUM             = 20;
  localparam int unsigned SOS_WORDS_PER_SECTION = 5;

  typedef struct packed {
    logic [2:1][COF_WD-1:0] sos_coeff_a;
    logic [2:0][COF_WD-1:0] sos_coeff_b;
  } TYDE_SOS_COEFF_DATA_COF_WD;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_PEND = 1'b1
  } loader_state_e;

  // b0 = 1.0 in Q(SHIFT_NUM), all other taps zero: the section passes input through.
  function automatic TYDE_SOS_COEFF_DATA_COF_WD unity_coeff();
    TYDE_SOS_COEFF_DATA_COF_WD c;
    c                = '0;
    c.sos_coeff_b[0] = COF_WD'(1 << SHIFT_NUM);
    return c;
  endfunction

endpackage

// File: rtl/sos_coeff_bank.sv
// Shadow/active coefficient register pair for one second-order section.
// Words land in the shadow copy by index; commit copies shadow to active.
module sos_coeff_bank
  import ae_iir_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [2:0]                wr_idx_i,
  input  logic [COF_WD-1:0]         wr_data_i,
  input  logic                      commit_i,
  output TYDE_SOS_COEFF_DATA_COF_WD active_o
);

  TYDE_SOS_COEFF_DATA_COF_WD shadow_q, shadow_d;
  TYDE_SOS_COEFF_DATA_COF_WD active_q, active_d;

  // Index order on the wire is b0, b1, b2, a1, a2.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i) begin
      case (wr_idx_i)
        3'd0:    shadow_d.sos_coeff_b[0] = wr_data_i;
        3'd1:    shadow_d.sos_coeff_b[1] = wr_data_i;
        3'd2:    shadow_d.sos_coeff_b[2] = wr_data_i;
        3'd3:    shadow_d.sos_coeff_a[1] = wr_data_i;
        3'd4:    shadow_d.sos_coeff_a[2] = wr_data_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    active_d = active_q;
    if (commit_i) active_d = shadow_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= unity_coeff();
      active_q <= unity_coeff();
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/sos_coeff_loader.sv
// Streams 5*NUM_SOS coefficient words into shadow banks and commits them all
// atomically to the active banks on the first sample strobe after a full load.
module sos_coeff_loader
  import ae_iir_pkg::*;
#(
  parameter int unsigned NUM_SOS = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    en_i,
  input  logic                                    coeff_valid_i,
  input  logic [COF_WD-1:0]                       coeff_data_i,
  output logic                                    coeff_ready_o,
  input  logic                                    abort_i,
  output TYDE_SOS_COEFF_DATA_COF_WD [NUM_SOS-1:0] sos_coeff_o,
  output logic                                    pending_o,
  output logic                                    commit_o
);

  localparam int unsigned SEC_W     = (NUM_SOS > 1) ? $clog2(NUM_SOS) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(NUM_SOS - 1);
  localparam logic [2:0]       IDX_LAST = 3'(SOS_WORDS_PER_SECTION - 1);

  loader_state_e    state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             commit_q, commit_d;
  logic             xfer;

  // A word arriving together with abort is dropped.
  assign xfer = coeff_valid_i & coeff_ready_o & ~abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_LOAD;
      idx_q    <= '0;
      sec_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sec_q    <= sec_d;
      commit_q <= commit_d;
    end
  end

  // Abort overrides everything, including a strobe that would commit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sec_d    = sec_q;
    commit_d = 1'b0;
    if (abort_i) begin
      state_d = S_LOAD;
      idx_d   = '0;
      sec_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (xfer) begin
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              if (sec_q == SEC_LAST) begin
                sec_d   = '0;
                state_d = S_PEND;
              end else begin
                sec_d = sec_q + SEC_W'(1);
              end
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        S_PEND: begin
          if (en_i) begin
            commit_d = 1'b1;
            idx_d    = '0;
            sec_d    = '0;
            state_d  = S_LOAD;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  always_comb begin
    coeff_ready_o = 1'b0;
    pending_o     = 1'b0;
    case (state_q)
      S_LOAD:  coeff_ready_o = 1'b1;
      S_PEND:  pending_o     = 1'b1;
      default: ;
    endcase
  end

  assign commit_o = commit_q;

  for (genvar s = 0; s < NUM_SOS; s++) begin : g_bank
    sos_coeff_bank u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (xfer && (sec_q == SEC_W'(s))),
      .wr_idx_i  (idx_q),
      .wr_data_i (coeff_data_i),
      .commit_i  (commit_d),
      .active_o  (sos_coeff_o[s])
    );
  end

endmodule

// File: tb/tb_sos_coeff_loader.sv
// Directed bench for sos_coeff_loader: streaming, commit timing, abort and
// asynchronous reset, checked against a bench-side expected active bank.
module tb_sos_coeff_loader;
  import ae_iir_pkg::*;

  localparam int unsigned NUM_SOS = 4;
  localparam int unsigned NWORDS  = NUM_SOS * 5;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic en_i;
  logic coeff_valid_i;
  logic [COF_WD-1:0] coeff_data_i;
  logic coeff_ready_o;
  logic abort_i;
  TYDE_SOS_COEFF_DATA_COF_WD [NUM_SOS-1:0] sos_coeff_o;
  logic pending_o;
  logic commit_o;

  int total = 0;
  int bad   = 0;
  logic [COF_WD-1:0] exp_act [NUM_SOS][5];

  sos_coeff_loader #(.NUM_SOS(NUM_SOS)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .en_i          (en_i),
    .coeff_valid_i (coeff_valid_i),
    .coeff_data_i  (coeff_data_i),
    .coeff_ready_o (coeff_ready_o),
    .abort_i       (abort_i),
    .sos_coeff_o   (sos_coeff_o),
    .pending_o     (pending_o),
    .commit_o      (commit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [COF_WD-1:0] dut_word(input int s, input int i);
    case (i)
      0:       return sos_coeff_o[s].sos_coeff_b[0];
      1:       return sos_coeff_o[s].sos_coeff_b[1];
      2:       return sos_coeff_o[s].sos_coeff_b[2];
      3:       return sos_coeff_o[s].sos_coeff_a[1];
      default: return sos_coeff_o[s].sos_coeff_a[2];
    endcase
  endfunction

  task automatic set_unity();
    for (int s = 0; s < NUM_SOS; s++)
      for (int i = 0; i < 5; i++)
        exp_act[s][i] = (i == 0) ? 24'h100000 : 24'h0;
  endtask

  // Word k of a stream (0-based) is base+k, landing in section k/5, slot k%5.
  task automatic set_stream(input int base);
    for (int s = 0; s < NUM_SOS; s++)
      for (int i = 0; i < 5; i++)
        exp_act[s][i] = COF_WD'(base + 5 * s + i);
  endtask

  task automatic check_bank(input string tag);
    for (int s = 0; s < NUM_SOS; s++)
      for (int i = 0; i < 5; i++)
        chk($sformatf("%s s%0d w%0d", tag, s, i), 32'(dut_word(s, i)), 32'(exp_act[s][i]));
  endtask

  task automatic send_word(input int v);
    coeff_valid_i = 1'b1;
    coeff_data_i  = COF_WD'(v);
    tick();
    coeff_valid_i = 1'b0;
  endtask

  task automatic load_all(input int base);
    for (int k = 0; k < int'(NWORDS); k++) send_word(base + k);
  endtask

  task automatic strobe_commit(input string tag, input int base);
    en_i = 1'b1;
    tick();
    en_i = 1'b0;
    set_stream(base);
    chk({tag, " commit"}, 32'(commit_o), 32'd1);
    chk({tag, " ready"}, 32'(coeff_ready_o), 32'd1);
    chk({tag, " pending"}, 32'(pending_o), 32'd0);
    check_bank(tag);
    tick();
    chk({tag, " commit_pulse_end"}, 32'(commit_o), 32'd0);
  endtask

  initial begin
    int sent;
    int c;
    rst_ni        = 1'b0;
    en_i          = 1'b0;
    coeff_valid_i = 1'b0;
    coeff_data_i  = '0;
    abort_i       = 1'b0;
    #12;
    rst_ni = 1'b1;
    tick();

    // Reset state
    set_unity();
    chk("rst ready", 32'(coeff_ready_o), 32'd1);
    chk("rst pending", 32'(pending_o), 32'd0);
    chk("rst commit", 32'(commit_o), 32'd0);
    check_bank("rst");

    // Contiguous stream 1..20
    load_all(1);
    chk("s1 pending", 32'(pending_o), 32'd1);
    chk("s1 ready", 32'(coeff_ready_o), 32'd0);
    chk("s1 commit_before_en", 32'(commit_o), 32'd0);
    check_bank("s1 hold");
    strobe_commit("s1", 1);
    chk("s1 s0b0", 32'(sos_coeff_o[0].sos_coeff_b[0]), 32'd1);
    chk("s1 s3a2", 32'(sos_coeff_o[3].sos_coeff_a[2]), 32'd20);

    // Gappy stream 101..120 with strobes every 7 cycles during load
    sent = 0;
    c    = 0;
    while (sent < int'(NWORDS) && c < 200) begin
      coeff_valid_i = (c % 2 == 0);
      coeff_data_i  = COF_WD'(101 + sent);
      en_i          = (c % 7 == 6);
      tick();
      if (coeff_valid_i) sent++;
      chk("s2 no_early_commit", 32'(commit_o), 32'd0);
      c++;
    end
    coeff_valid_i = 1'b0;
    en_i          = 1'b0;
    chk("s2 words_sent", 32'(sent), 32'(NWORDS));
    tick();
    chk("s2 pending", 32'(pending_o), 32'd1);
    chk("s2 commit_idle", 32'(commit_o), 32'd0);
    check_bank("s2 hold");
    strobe_commit("s2", 101);

    // Last word coincides with strobe: no commit until the next strobe
    for (int k = 0; k < int'(NWORDS) - 1; k++) send_word(201 + k);
    en_i = 1'b1;
    send_word(201 + NWORDS - 1);
    en_i = 1'b0;
    chk("s3 no_commit_same_cycle", 32'(commit_o), 32'd0);
    tick();
    chk("s3 no_commit_later", 32'(commit_o), 32'd0);
    chk("s3 pending", 32'(pending_o), 32'd1);
    check_bank("s3 hold");
    strobe_commit("s3", 201);

    // Abort together with strobe in S_PEND: abort wins
    load_all(301);
    chk("s4 pending", 32'(pending_o), 32'd1);
    en_i    = 1'b1;
    abort_i = 1'b1;
    tick();
    en_i    = 1'b0;
    abort_i = 1'b0;
    chk("s4 abort_commit", 32'(commit_o), 32'd0);
    chk("s4 abort_ready", 32'(coeff_ready_o), 32'd1);
    chk("s4 abort_pending", 32'(pending_o), 32'd0);
    tick();
    chk("s4 abort_commit_late", 32'(commit_o), 32'd0);
    check_bank("s4 kept");
    // Partial load, then abort with a word in flight that must be dropped
    for (int k = 0; k < 3; k++) send_word(900 + k);
    abort_i = 1'b1;
    send_word(999);
    abort_i = 1'b0;
    load_all(401);
    chk("s4 reload_pending", 32'(pending_o), 32'd1);
    strobe_commit("s4", 401);

    // Asynchronous reset after 7 words
    for (int k = 0; k < 7; k++) send_word(501 + k);
    #2;
    rst_ni = 1'b0;
    #1;
    set_unity();
    chk("s5 async_ready", 32'(coeff_ready_o), 32'd1);
    chk("s5 async_pending", 32'(pending_o), 32'd0);
    chk("s5 async_commit", 32'(commit_o), 32'd0);
    check_bank("s5 async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    check_bank("s5 after_rst");
    load_all(601);
    chk("s5 pending", 32'(pending_o), 32'd1);
    strobe_commit("s5", 601);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
